// File: rtl/ma_pkg.sv
// Shared sizing helpers and the stage-1 pipeline record for moving_average_mc.
// The record is sized for the largest supported configuration and narrowed at its use sites.
package ma_pkg;

  localparam int unsigned MaxDataW   = 64;
  localparam int unsigned MaxWinLog2 = 10;
  localparam int unsigned MaxChanW   = 6;
  localparam int unsigned MaxSumW    = MaxDataW + MaxWinLog2;

  function automatic int unsigned sum_width(input int unsigned data_width,
                                            input int unsigned window_log2);
    return data_width + window_log2;
  endfunction

  function automatic int unsigned chan_width(input int unsigned channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

  typedef struct packed {
    logic                         valid;
    logic [MaxChanW-1:0]          chan;
    logic signed [MaxDataW-1:0]   data;
    logic signed [MaxDataW-1:0]   old;
    logic signed [MaxSumW-1:0]    sum;
    logic [MaxWinLog2-1:0]        ptr;
    logic [MaxWinLog2:0]          fill;
  } s1_rec_t;

endpackage

// File: rtl/moving_average_mc_if.sv
// Sample-in / result-out bundle for moving_average_mc, including the synchronous flush.
interface moving_average_mc_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CHANNELS   = 8
);
  localparam int unsigned ChanW = ma_pkg::chan_width(CHANNELS);

  logic                         flush;
  logic                         in_valid;
  logic [ChanW-1:0]             in_chan;
  logic signed [DATA_WIDTH-1:0] in_data;
  logic                         out_valid;
  logic [ChanW-1:0]             out_chan;
  logic signed [DATA_WIDTH-1:0] out_data;
  logic                         out_full;

  modport master (
    output flush, in_valid, in_chan, in_data,
    input  out_valid, out_chan, out_data, out_full
  );

  modport slave (
    input  flush, in_valid, in_chan, in_data,
    output out_valid, out_chan, out_data, out_full
  );
endinterface

// File: rtl/ma_window_ram.sv
// Per-channel delay-line storage: async read, sync write, addressed as {chan, ptr}.
module ma_window_ram #(
  parameter int unsigned DataW = 32,
  parameter int unsigned AddrW = 7,
  parameter int unsigned Depth = 128
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [DataW-1:0] wdata_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [DataW-1:0] rdata_o
);
  logic [DataW-1:0] mem [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem[raddr_i];
endmodule

// File: rtl/moving_average_mc.sv
// Time-multiplexed per-channel moving average, 2-cycle latency, one shared running-sum datapath.
// Define MA_ROUNDING_EN for round-half-up output instead of floor.
module moving_average_mc
  import ma_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned WINDOW_LOG2 = 4,
  parameter int unsigned CHANNELS    = 8
) (
  input logic                clk,
  input logic                rst,
  moving_average_mc_if.slave bus
);
  localparam int unsigned SumW  = sum_width(DATA_WIDTH, WINDOW_LOG2);
  localparam int unsigned ChanW = chan_width(CHANNELS);
  localparam int unsigned Win   = 2 ** WINDOW_LOG2;
  localparam int unsigned AddrW = ChanW + WINDOW_LOG2;
  localparam int unsigned Depth = CHANNELS * Win;

  typedef logic [ChanW-1:0]             chan_t;
  typedef logic [WINDOW_LOG2-1:0]       ptr_t;
  typedef logic [WINDOW_LOG2:0]         fill_t;
  typedef logic signed [DATA_WIDTH-1:0] data_t;
  typedef logic signed [SumW-1:0]       sum_t;

  localparam fill_t FillMax = fill_t'(Win);

  if (DATA_WIDTH > MaxDataW || WINDOW_LOG2 > MaxWinLog2 || ChanW > MaxChanW) begin : g_bad_cfg
    $error("moving_average_mc: parameters exceed the stage-1 record");
  end

  sum_t    sum_q  [CHANNELS];
  sum_t    sum_d  [CHANNELS];
  ptr_t    ptr_q  [CHANNELS];
  ptr_t    ptr_d  [CHANNELS];
  fill_t   fill_q [CHANNELS];
  fill_t   fill_d [CHANNELS];
  s1_rec_t s1_q, s1_d;

  logic  out_valid_q, out_valid_d, out_full_q, out_full_d;
  chan_t out_chan_q, out_chan_d;
  data_t out_data_q, out_data_d;

  logic             accept;
  chan_t            rd_chan, wr_chan;
  ptr_t             rd_ptr, wr_ptr, new_ptr;
  fill_t            rd_fill, wr_fill, new_fill;
  sum_t             rd_sum, new_sum;
  data_t            ram_rdata, wdata, rd_old, avg;
  logic             fwd;
  logic [AddrW-1:0] raddr, waddr;

  // Stage 2: update for the sample registered last cycle.
  always_comb begin
    wr_chan  = chan_t'(s1_q.chan);
    wr_ptr   = ptr_t'(s1_q.ptr);
    wr_fill  = fill_t'(s1_q.fill);
    wdata    = data_t'(s1_q.data);
    new_sum  = sum_t'(s1_q.sum + s1_q.data - s1_q.old);
    new_ptr  = wr_ptr + ptr_t'(1);
    new_fill = (wr_fill == FillMax) ? FillMax : wr_fill + fill_t'(1);
    waddr    = {wr_chan, wr_ptr};
  end

`ifdef MA_ROUNDING_EN
  typedef logic signed [SumW:0] sum_ext_t;
  sum_ext_t sum_rnd;
  always_comb begin
    sum_rnd = sum_ext_t'(new_sum) + sum_ext_t'(Win / 2);
    avg     = data_t'(sum_rnd >>> WINDOW_LOG2);
  end
`else
  always_comb begin
    avg = data_t'(new_sum >>> WINDOW_LOG2);
  end
`endif

  // Stage 1: read channel state, bypassing the stage-2 writeback when it targets the same channel.
  always_comb begin
    accept  = bus.in_valid && !bus.flush && (32'(bus.in_chan) < CHANNELS);
    rd_chan = accept ? bus.in_chan : '0;
    fwd     = s1_q.valid && (wr_chan == rd_chan);
    rd_sum  = fwd ? new_sum  : sum_q[rd_chan];
    rd_ptr  = fwd ? new_ptr  : ptr_q[rd_chan];
    rd_fill = fwd ? new_fill : fill_q[rd_chan];
    raddr   = {rd_chan, rd_ptr};
    rd_old  = (s1_q.valid && waddr == raddr) ? wdata : ram_rdata;
    if (rd_fill != FillMax) begin
      rd_old = '0;
    end
    s1_d       = '0;
    s1_d.valid = accept;
    s1_d.chan  = MaxChanW'(rd_chan);
    s1_d.data  = MaxDataW'(bus.in_data);
    s1_d.old   = MaxDataW'(rd_old);
    s1_d.sum   = MaxSumW'(rd_sum);
    s1_d.ptr   = MaxWinLog2'(rd_ptr);
    s1_d.fill  = (MaxWinLog2 + 1)'(rd_fill);
  end

  always_comb begin
    sum_d  = sum_q;
    ptr_d  = ptr_q;
    fill_d = fill_q;
    if (bus.flush) begin
      for (int c = 0; c < CHANNELS; c++) begin
        sum_d[c]  = '0;
        ptr_d[c]  = '0;
        fill_d[c] = '0;
      end
    end else if (s1_q.valid) begin
      sum_d[wr_chan]  = new_sum;
      ptr_d[wr_chan]  = new_ptr;
      fill_d[wr_chan] = new_fill;
    end
  end

  always_comb begin
    out_valid_d = s1_q.valid && !bus.flush;
    out_chan_d  = out_chan_q;
    out_data_d  = out_data_q;
    out_full_d  = out_full_q;
    if (s1_q.valid) begin
      out_chan_d = wr_chan;
      out_data_d = avg;
      out_full_d = (new_fill == FillMax);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < CHANNELS; c++) begin
        sum_q[c]  <= '0;
        ptr_q[c]  <= '0;
        fill_q[c] <= '0;
      end
      s1_q        <= '0;
      out_valid_q <= 1'b0;
      out_chan_q  <= '0;
      out_data_q  <= '0;
      out_full_q  <= 1'b0;
    end else begin
      sum_q       <= sum_d;
      ptr_q       <= ptr_d;
      fill_q      <= fill_d;
      s1_q        <= s1_d;
      out_valid_q <= out_valid_d;
      out_chan_q  <= out_chan_d;
      out_data_q  <= out_data_d;
      out_full_q  <= out_full_d;
    end
  end

  ma_window_ram #(
    .DataW (DATA_WIDTH),
    .AddrW (AddrW),
    .Depth (Depth)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (s1_q.valid),
    .waddr_i (waddr),
    .wdata_i (wdata),
    .raddr_i (raddr),
    .rdata_o (ram_rdata)
  );

  assign bus.out_valid = out_valid_q;
  assign bus.out_chan  = out_chan_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_full  = out_full_q;
endmodule

// File: tb/tb_moving_average_mc.sv
// Scoreboard bench for moving_average_mc: W=16/8-channel DUT against a window model,
// plus a W=4/6-channel DUT for rounding and out-of-range channel checks.
module tb_moving_average_mc;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  moving_average_mc_if #(.DATA_WIDTH(16), .CHANNELS(8)) bus_a ();
  moving_average_mc_if #(.DATA_WIDTH(16), .CHANNELS(6)) bus_b ();

  moving_average_mc #(.DATA_WIDTH(16), .WINDOW_LOG2(4), .CHANNELS(8)) u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a.slave)
  );

  moving_average_mc #(.DATA_WIDTH(16), .WINDOW_LOG2(2), .CHANNELS(6)) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b.slave)
  );

  typedef struct {
    int chan;
    int data;
    bit full;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   m_win  [8][16];
  int   m_ptr  [8];
  int   m_fill [8];
  bit   last_pushed;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running, want finish");
    $fatal(1);
  end

  task automatic model_clear();
    for (int c = 0; c < 8; c++) begin
      m_ptr[c]  = 0;
      m_fill[c] = 0;
    end
  endtask

  // Plain window model: sum the valid entries directly, no running sum.
  task automatic model_push(input int ch, input int d);
    exp_t   e;
    longint s = 0;
    m_win[ch][m_ptr[ch]] = d;
    m_ptr[ch] = (m_ptr[ch] + 1) % 16;
    if (m_fill[ch] < 16) m_fill[ch]++;
    for (int i = 0; i < m_fill[ch]; i++) s += m_win[ch][i];
`ifdef MA_ROUNDING_EN
    s += 8;
`endif
    e.chan = ch;
    e.data = int'(s >>> 4);
    e.full = (m_fill[ch] == 16);
    e.cyc  = cyc + 2;
    sb.push_back(e);
  endtask

  // One clock of stimulus on DUT A; results are popped and compared on the falling edge.
  task automatic step_a(input bit v, input int ch, input int d, input bit fl);
    exp_t e;
    bus_a.in_valid = v;
    bus_a.in_chan  = 3'(ch);
    bus_a.in_data  = 16'(d);
    bus_a.flush    = fl;
    if (fl) begin
      if (last_pushed) sb.delete(sb.size() - 1);
      model_clear();
      last_pushed = 1'b0;
    end else if (v) begin
      model_push(ch, d);
      last_pushed = 1'b1;
    end else begin
      last_pushed = 1'b0;
    end
    @(negedge clk);
    if (rst && bus_a.out_valid) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected: got chan=%0d data=%0d, want no output",
                 bus_a.out_chan, bus_a.out_data);
      end else begin
        e = sb.pop_front();
        if (int'(bus_a.out_data) !== e.data || int'(bus_a.out_chan) !== e.chan ||
            bus_a.out_full !== e.full || cyc !== e.cyc) begin
          bad++;
          $display("FAIL sb_result: got chan=%0d data=%0d full=%0d cyc=%0d, want chan=%0d data=%0d full=%0d cyc=%0d",
                   bus_a.out_chan, bus_a.out_data, bus_a.out_full, cyc,
                   e.chan, e.data, e.full, e.cyc);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 8 && sb.size() != 0; i++) step_a(0, 0, 0, 0);
    step_a(0, 0, 0, 0);
    step_a(0, 0, 0, 0);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL %s_drain: got %0d results outstanding, want 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    total += 6;
    if (bus_a.out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", bus_a.out_valid); end
    if (bus_a.out_chan !== 3'd0) begin bad++; $display("FAIL rst_chan: got %0d want 0", bus_a.out_chan); end
    if (bus_a.out_data !== 16'sd0) begin bad++; $display("FAIL rst_data: got %0d want 0", bus_a.out_data); end
    if (bus_a.out_full !== 1'b0) begin bad++; $display("FAIL rst_full: got %b want 0", bus_a.out_full); end
    if (bus_b.out_valid !== 1'b0) begin bad++; $display("FAIL rst_b_valid: got %b want 0", bus_b.out_valid); end
    if (bus_b.out_data !== 16'sd0) begin bad++; $display("FAIL rst_b_data: got %0d want 0", bus_b.out_data); end
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_fill();
    for (int k = 0; k < 16; k++) step_a(1, 0, 100, 0);
  endtask

  task automatic test_slide();
    for (int k = 0; k < 16; k++) step_a(1, 0, -50, 0);
    drain("slide");
  endtask

  task automatic test_overflow();
    for (int k = 0; k < 16; k++) step_a(1, 5, 32767, 0);
    for (int k = 0; k < 16; k++) step_a(1, 5, -32767, 0);
    drain("overflow");
  endtask

  task automatic test_back_to_back();
    int pat [10] = '{0, 0, 3, 0, 3, 3, 3, 0, 0, 3};
    int d;
    for (int i = 0; i < 10; i++) begin
      d = int'($urandom_range(65534)) - 32767;
      step_a(1, pat[i], d, 0);
    end
    for (int i = 0; i < 120; i++) begin
      d = int'($urandom_range(65534)) - 32767;
      if ($urandom_range(4) == 0) step_a(0, 0, 0, 0);
      else step_a(1, int'($urandom_range(7)), d, 0);
    end
    drain("b2b");
  endtask

  task automatic test_flush();
    step_a(1, 2, 40, 0);
    step_a(0, 0, 0, 0);
    step_a(0, 0, 0, 0);
    step_a(1, 2, 50, 0);
    step_a(1, 2, 70, 1);
    step_a(1, 2, 160, 0);
    drain("flush");
  endtask

  task automatic test_rounding();
    int exp_r [3];
`ifdef MA_ROUNDING_EN
    exp_r = '{0, 1, 0};
`else
    exp_r = '{0, 0, -1};
`endif
    bus_b.in_valid = 1'b1; bus_b.in_chan = 3'd1; bus_b.in_data = 16'sd1;
    step_a(0, 0, 0, 0);
    step_a(0, 0, 0, 0);
    total += 3;
    if (bus_b.out_valid !== 1'b1 || int'(bus_b.out_data) !== exp_r[0]) begin
      bad++; $display("FAIL rnd_first: got v=%b data=%0d want v=1 data=%0d",
                      bus_b.out_valid, bus_b.out_data, exp_r[0]);
    end
    if (bus_b.out_chan !== 3'd1) begin bad++; $display("FAIL rnd_chan: got %0d want 1", bus_b.out_chan); end
    bus_b.in_valid = 1'b0;
    step_a(0, 0, 0, 0);
    if (bus_b.out_valid !== 1'b1 || int'(bus_b.out_data) !== exp_r[1]) begin
      bad++; $display("FAIL rnd_second: got v=%b data=%0d want v=1 data=%0d",
                      bus_b.out_valid, bus_b.out_data, exp_r[1]);
    end
    bus_b.in_valid = 1'b1; bus_b.in_chan = 3'd2; bus_b.in_data = -16'sd2;
    step_a(0, 0, 0, 0);
    bus_b.in_valid = 1'b0;
    step_a(0, 0, 0, 0);
    total++;
    if (bus_b.out_valid !== 1'b1 || int'(bus_b.out_data) !== exp_r[2]) begin
      bad++; $display("FAIL rnd_neg: got v=%b data=%0d want v=1 data=%0d",
                      bus_b.out_valid, bus_b.out_data, exp_r[2]);
    end
  endtask

  task automatic test_bad_chan();
    bus_b.in_valid = 1'b1; bus_b.in_chan = 3'd6; bus_b.in_data = 16'sd400;
    step_a(0, 0, 0, 0);
    bus_b.in_chan = 3'd7;
    step_a(0, 0, 0, 0);
    bus_b.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step_a(0, 0, 0, 0);
      total++;
      if (bus_b.out_valid !== 1'b0) begin
        bad++; $display("FAIL bad_chan_%0d: got out_valid=%b chan=%0d want 0", i,
                        bus_b.out_valid, bus_b.out_chan);
      end
    end
    // A valid channel still works afterwards: 8 into an empty W=4 window.
    bus_b.in_valid = 1'b1; bus_b.in_chan = 3'd0; bus_b.in_data = 16'sd8;
    step_a(0, 0, 0, 0);
    bus_b.in_valid = 1'b0;
    step_a(0, 0, 0, 0);
    total++;
    if (bus_b.out_valid !== 1'b1 || bus_b.out_data !== 16'sd2 || bus_b.out_full !== 1'b0) begin
      bad++; $display("FAIL bad_chan_after: got v=%b data=%0d full=%b want v=1 data=2 full=0",
                      bus_b.out_valid, bus_b.out_data, bus_b.out_full);
    end
  endtask

  task automatic test_async_reset();
    for (int k = 1; k <= 3; k++) step_a(1, 4, 1000 * k, 0);
    #2;
    rst = 1'b0;
    #1;
    total += 4;
    if (bus_a.out_valid !== 1'b0) begin bad++; $display("FAIL arst_valid: got %b want 0", bus_a.out_valid); end
    if (bus_a.out_chan !== 3'd0) begin bad++; $display("FAIL arst_chan: got %0d want 0", bus_a.out_chan); end
    if (bus_a.out_data !== 16'sd0) begin bad++; $display("FAIL arst_data: got %0d want 0", bus_a.out_data); end
    if (bus_a.out_full !== 1'b0) begin bad++; $display("FAIL arst_full: got %b want 0", bus_a.out_full); end
    sb.delete();
    model_clear();
    last_pushed    = 1'b0;
    bus_a.in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    step_a(1, 4, 160, 0);
    drain("arst");
  endtask

  initial begin
    rst = 1'b0;
    bus_a.flush = 1'b0; bus_a.in_valid = 1'b0; bus_a.in_chan = '0; bus_a.in_data = '0;
    bus_b.flush = 1'b0; bus_b.in_valid = 1'b0; bus_b.in_chan = '0; bus_b.in_data = '0;
    for (int c = 0; c < 8; c++) for (int i = 0; i < 16; i++) m_win[c][i] = 0;
    model_clear();
    last_pushed = 1'b0;
    test_reset();
    test_fill();
    test_slide();
    test_overflow();
    test_back_to_back();
    test_flush();
    test_rounding();
    test_bad_chan();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
